// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN layer constants, sizing helpers and conv sequencer state type
// Purpose: layer constants used as defaults by the convolution stage, helpers
//          that derive output edge length and address widths, and the
//          state enum for the conv sequencer FSM.
// Ports:   none (package).
package cnn_pkg;

    localparam int conv_input_size  = 28;
    localparam int conv_filter_size = 7;
    localparam int conv_num_filters = 16;
    localparam int conv_stride      = 2;
    localparam int pooling_size     = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } conv_seq_state_t;

    // Output edge length of a valid (unpadded) strided convolution.
    function automatic int conv_out_size(input int in_size, input int filt, input int stride);
        return (in_size - filt) / stride + 1;
    endfunction

    // Bits needed to index n items; never narrower than one bit.
    function automatic int cnn_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - nested tap/window counters and memory address arithmetic for the conv sequencer
// Purpose: holds the kx, ky, c, r, f counters (kx fastest) and derives the
//          input-feature, weight and output addresses from them.
// Ports:   clk, rstb        clock, async active-low reset
//          clear_i          zero every counter
//          step_tap_i       advance kx/ky (wraps ky/kx back to 0 after the last tap)
//          step_win_i       advance c/r/f (wraps to 0 after the last window)
//          first_tap_o      current tap is kx=ky=0
//          last_tap_o       current tap is kx=ky=FILTER_SIZE-1
//          last_win_o       current window is f=NUM_FILTERS-1, r=c=OUT_SIZE-1
//          in_addr_o        (r*STRIDE+ky)*INPUT_SIZE + c*STRIDE + kx
//          w_addr_o         f*TAPS + ky*FILTER_SIZE + kx
//          out_addr_o       f*OUT_SIZE^2 + r*OUT_SIZE + c
module conv_addr_gen
    import cnn_pkg::*;
#(
    parameter int INPUT_SIZE  = conv_input_size,
    parameter int FILTER_SIZE = conv_filter_size,
    parameter int NUM_FILTERS = conv_num_filters,
    parameter int STRIDE      = conv_stride,
    localparam int OUT_SIZE   = conv_out_size(INPUT_SIZE, FILTER_SIZE, STRIDE),
    localparam int TAPS       = FILTER_SIZE * FILTER_SIZE,
    localparam int IN_AW      = cnn_width(INPUT_SIZE * INPUT_SIZE),
    localparam int W_AW       = cnn_width(NUM_FILTERS * TAPS),
    localparam int OUT_AW     = cnn_width(NUM_FILTERS * OUT_SIZE * OUT_SIZE)
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              clear_i,
    input  logic              step_tap_i,
    input  logic              step_win_i,
    output logic              first_tap_o,
    output logic              last_tap_o,
    output logic              last_win_o,
    output logic [IN_AW-1:0]  in_addr_o,
    output logic [W_AW-1:0]   w_addr_o,
    output logic [OUT_AW-1:0] out_addr_o
);

    localparam int KW = cnn_width(FILTER_SIZE);
    localparam int PW = cnn_width(OUT_SIZE);
    localparam int FW = cnn_width(NUM_FILTERS);

    localparam logic [KW-1:0] K_MAX = KW'(FILTER_SIZE - 1);
    localparam logic [PW-1:0] P_MAX = PW'(OUT_SIZE - 1);
    localparam logic [FW-1:0] F_MAX = FW'(NUM_FILTERS - 1);

    logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
    logic [PW-1:0] c_q, c_d, r_q, r_d;
    logic [FW-1:0] f_q, f_d;

    always_comb begin
        kx_d = kx_q;
        ky_d = ky_q;
        c_d  = c_q;
        r_d  = r_q;
        f_d  = f_q;
        if (clear_i) begin
            kx_d = '0;
            ky_d = '0;
            c_d  = '0;
            r_d  = '0;
            f_d  = '0;
        end else if (step_tap_i) begin
            if (kx_q == K_MAX) begin
                kx_d = '0;
                ky_d = (ky_q == K_MAX) ? '0 : ky_q + 1'b1;
            end else begin
                kx_d = kx_q + 1'b1;
            end
        end else if (step_win_i) begin
            if (c_q == P_MAX) begin
                c_d = '0;
                if (r_q == P_MAX) begin
                    r_d = '0;
                    f_d = (f_q == F_MAX) ? '0 : f_q + 1'b1;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end else begin
                c_d = c_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            kx_q <= '0;
            ky_q <= '0;
            c_q  <= '0;
            r_q  <= '0;
            f_q  <= '0;
        end else begin
            kx_q <= kx_d;
            ky_q <= ky_d;
            c_q  <= c_d;
            r_q  <= r_d;
            f_q  <= f_d;
        end
    end

    assign first_tap_o = (kx_q == '0) && (ky_q == '0);
    assign last_tap_o  = (kx_q == K_MAX) && (ky_q == K_MAX);
    assign last_win_o  = (c_q == P_MAX) && (r_q == P_MAX) && (f_q == F_MAX);

    // Only constant multiplies on registered counters.
    assign in_addr_o  = IN_AW'((32'(r_q) * STRIDE + 32'(ky_q)) * INPUT_SIZE
                               + 32'(c_q) * STRIDE + 32'(kx_q));
    assign w_addr_o   = W_AW'(32'(f_q) * TAPS + 32'(ky_q) * FILTER_SIZE + 32'(kx_q));
    assign out_addr_o = OUT_AW'(32'(f_q) * (OUT_SIZE * OUT_SIZE) + 32'(r_q) * OUT_SIZE + 32'(c_q));

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - time-multiplexed convolution sequencer driving one shared MAC
// Purpose: walks every (f, r, c, ky, kx) tap, issues memory reads, delays the
//          MAC strobes by the one-cycle read latency and hands each finished
//          output pixel to the write path with a valid/ready handshake.
// Build option: CONV_SEQ_PERF_CNT_EN adds stall_cycles / pass_cycles counters.
// Ports:   clk, rstb          clock, async active-low reset
//          start              begin a layer pass (sampled in IDLE only)
//          busy, done         pass in progress / one-cycle end-of-layer pulse
//          mem_rd_en          read strobe to input and weight memories
//          in_addr, w_addr    input pixel / weight read addresses
//          mac_en/first/last  MAC strobes aligned with returned read data
//          out_valid/ready    output pixel handshake, out_addr held while valid
//          stall_cycles       (option) WRITE cycles with out_ready low
//          pass_cycles        (option) busy cycles of the last pass
module conv_sequencer
    import cnn_pkg::*;
#(
    parameter int INPUT_SIZE  = conv_input_size,
    parameter int FILTER_SIZE = conv_filter_size,
    parameter int NUM_FILTERS = conv_num_filters,
    parameter int STRIDE      = conv_stride,
    localparam int OUT_SIZE   = conv_out_size(INPUT_SIZE, FILTER_SIZE, STRIDE),
    localparam int TAPS       = FILTER_SIZE * FILTER_SIZE,
    localparam int IN_AW      = cnn_width(INPUT_SIZE * INPUT_SIZE),
    localparam int W_AW       = cnn_width(NUM_FILTERS * TAPS),
    localparam int OUT_AW     = cnn_width(NUM_FILTERS * OUT_SIZE * OUT_SIZE)
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [IN_AW-1:0]  in_addr,
    output logic [W_AW-1:0]   w_addr,
    output logic              mac_en,
    output logic              mac_first,
    output logic              mac_last,
    output logic              out_valid,
`ifdef CONV_SEQ_PERF_CNT_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       pass_cycles,
`endif
    output logic [OUT_AW-1:0] out_addr
);

    conv_seq_state_t state_q, state_d;
    logic clear, step_tap, step_win;
    logic first_tap, last_tap, last_win;
    logic mac_en_q, mac_first_q, mac_last_q;

    conv_addr_gen #(
        .INPUT_SIZE  (INPUT_SIZE),
        .FILTER_SIZE (FILTER_SIZE),
        .NUM_FILTERS (NUM_FILTERS),
        .STRIDE      (STRIDE)
    ) u_addr_gen (
        .clk         (clk),
        .rstb        (rstb),
        .clear_i     (clear),
        .step_tap_i  (step_tap),
        .step_win_i  (step_win),
        .first_tap_o (first_tap),
        .last_tap_o  (last_tap),
        .last_win_o  (last_win),
        .in_addr_o   (in_addr),
        .w_addr_o    (w_addr),
        .out_addr_o  (out_addr)
    );

    always_comb begin
        state_d   = state_q;
        clear     = 1'b0;
        step_tap  = 1'b0;
        step_win  = 1'b0;
        mem_rd_en = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                mem_rd_en = 1'b1;
                step_tap  = 1'b1;
                if (last_tap) state_d = DRAIN;
            end
            // Lets the final tap's read data reach the MAC before the result is offered.
            DRAIN: state_d = WRITE;
            WRITE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    step_win = 1'b1;
                    state_d  = last_win ? DONE : RUN;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            mac_en_q    <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            // One stage matches the fixed one-cycle memory read latency.
            mac_en_q    <= mem_rd_en;
            mac_first_q <= mem_rd_en & first_tap;
            mac_last_q  <= mem_rd_en & last_tap;
        end
    end

    assign mac_en    = mac_en_q;
    assign mac_first = mac_first_q;
    assign mac_last  = mac_last_q;

`ifdef CONV_SEQ_PERF_CNT_EN
    logic [31:0] stall_q, pass_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            stall_q <= '0;
            pass_q  <= '0;
        end else if (state_q == IDLE && start) begin
            stall_q <= '0;
            pass_q  <= '0;
        end else begin
            if (busy && pass_q != '1) pass_q <= pass_q + 32'd1;
            if (state_q == WRITE && !out_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign pass_cycles  = pass_q;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - self-checking bench for conv_sequencer on a 5x5 input, 3x3 kernel, 2 filter layer
module tb_conv_sequencer;

    localparam int IS   = 5;
    localparam int FS   = 3;
    localparam int NF   = 2;
    localparam int ST   = 2;
    localparam int OS   = (IS - FS) / ST + 1;
    localparam int TAPS = FS * FS;
    localparam int NW   = NF * OS * OS;

    logic       clk = 1'b0;
    logic       rstb;
    logic       start;
    logic       out_ready;
    logic       busy, done, mem_rd_en, mac_en, mac_first, mac_last, out_valid;
    logic [4:0] in_addr, w_addr;
    logic [2:0] out_addr;
`ifdef CONV_SEQ_PERF_CNT_EN
    logic [31:0] stall_cycles, pass_cycles;
`endif

    int n_tests  = 0;
    int n_fail   = 0;
    int cycles   = 0;

    always #5 clk = ~clk;

    conv_sequencer #(
        .INPUT_SIZE  (IS),
        .FILTER_SIZE (FS),
        .NUM_FILTERS (NF),
        .STRIDE      (ST)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .start        (start),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .mem_rd_en    (mem_rd_en),
        .in_addr      (in_addr),
        .w_addr       (w_addr),
        .mac_en       (mac_en),
        .mac_first    (mac_first),
        .mac_last     (mac_last),
        .out_valid    (out_valid),
`ifdef CONV_SEQ_PERF_CNT_EN
        .stall_cycles (stall_cycles),
        .pass_cycles  (pass_cycles),
`endif
        .out_addr     (out_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycles++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({busy, done, mem_rd_en, mac_en, mac_first, mac_last, out_valid,
                      in_addr, w_addr, out_addr}), 32'd0);
    endtask

    // One full layer pass, checked tap by tap against the loop-nest definition.
    // bp_win/bp_len force a stall of bp_len cycles in that window's WRITE;
    // rnd randomizes stray start pulses, out_ready outside WRITE and small stalls.
    task automatic run_pass(input int bp_win, input int bp_len, input bit rnd);
        int total_stall, stall, c0, f, r, c, ky, kx;
        total_stall = 0;
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        c0 = cycles;
        tick();
        for (int w = 0; w < NW; w++) begin
            f = w / (OS * OS);
            r = (w / OS) % OS;
            c = w % OS;
            for (int t = 0; t < TAPS; t++) begin
                ky = t / FS;
                kx = t % FS;
                start     = rnd ? 1'($urandom) : 1'b0;
                out_ready = rnd ? 1'($urandom) : 1'b1;
                chk("run_busy",    32'(busy),      32'd1);
                chk("run_rd_en",   32'(mem_rd_en), 32'd1);
                chk("run_valid",   32'(out_valid), 32'd0);
                chk("in_addr",     32'(in_addr),   32'((r * ST + ky) * IS + c * ST + kx));
                chk("w_addr",      32'(w_addr),    32'(f * TAPS + ky * FS + kx));
                chk("run_mac_en",  32'(mac_en),    32'(t != 0));
                chk("mac_first",   32'(mac_first), 32'(t == 1));
                chk("run_mac_last", 32'(mac_last), 32'd0);
                tick();
            end
            chk("drain_rd_en",   32'(mem_rd_en), 32'd0);
            chk("drain_mac_en",  32'(mac_en),    32'd1);
            chk("drain_mac_last", 32'(mac_last), 32'd1);
            chk("drain_first",   32'(mac_first), 32'd0);
            chk("drain_valid",   32'(out_valid), 32'd0);
            tick();
            stall = (w == bp_win) ? bp_len : (rnd ? int'($urandom_range(0, 2)) : 0);
            total_stall += stall;
            for (int k = 0; k <= stall; k++) begin
                out_ready = (k == stall);
                start     = rnd ? 1'($urandom) : 1'b0;
                chk("wr_valid",  32'(out_valid), 32'd1);
                chk("wr_addr",   32'(out_addr),  32'(f * OS * OS + r * OS + c));
                chk("wr_rd_en",  32'(mem_rd_en), 32'd0);
                chk("wr_mac_en", 32'(mac_en),    32'd0);
                chk("wr_done",   32'(done),      32'd0);
                tick();
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy",  32'(busy), 32'd1);
        chk("pass_len",   32'(cycles - c0), 32'(1 + NW * (TAPS + 2) + total_stall));
        tick();
        chk("done_once",  32'(done), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
`ifdef CONV_SEQ_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, 32'(total_stall));
        chk("pass_cycles",  pass_cycles,  32'(1 + NW * (TAPS + 2) + total_stall));
`endif
    endtask

    initial begin
        rstb      = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk_all_zero("reset_outputs");
        rstb = 1'b1;
        tick();
        chk_all_zero("idle_outputs");

        // Nominal pass, out_ready tied high.
        run_pass(-1, 0, 1'b0);

        // Five cycles of backpressure in the third WRITE.
        run_pass(2, 5, 1'b0);

        // Abort in the RUN phase of the fourth window.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3 * (TAPS + 2) + 4) begin
            chk("abort_no_done", 32'(done), 32'd0);
            tick();
        end
        chk("abort_in_run",  32'(mem_rd_en), 32'd1);
        chk("abort_out_win", 32'(out_addr),  32'd3);
        #2 rstb = 1'b0;
        #1;
        chk_all_zero("abort_async");
        tick();
        chk_all_zero("abort_held");
        rstb = 1'b1;
        tick();
        chk_all_zero("abort_idle");
`ifdef CONV_SEQ_PERF_CNT_EN
        chk("abort_stall_clr", stall_cycles, 32'd0);
        chk("abort_pass_clr",  pass_cycles,  32'd0);
`endif
        run_pass(-1, 0, 1'b0);

        // Randomized backpressure and stray start pulses while busy.
        for (int i = 0; i < 3; i++) run_pass(-1, 0, 1'b1);

        tick();
        chk("final_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
